// File: rtl/replay_pkg.sv
// replay_pkg: shared state encoding, buffer command codes and modulo sequence arithmetic
package replay_pkg;
    localparam int SEQ_W         = 12;
    localparam int WORDS_PER_TLP = 10;
    typedef logic [SEQ_W-1:0] seq_t;
    typedef enum logic [2:0] {IDLE, PURGE, REWIND, RETRAIN, LATCH, REPLAY} state_t;
    localparam logic [1:0] BUF_RD_NONE   = 2'b00;
    localparam logic [1:0] BUF_RD_PURGE  = 2'b01;
    localparam logic [1:0] BUF_RD_REWIND = 2'b10;
    function automatic seq_t seq_dist(input seq_t a, input seq_t b);
        return a - b;
    endfunction
endpackage

// File: rtl/replay_if.sv
// replay_if: DLLP decoder, TX path and replay buffer signals seen by the replay scheduler
interface replay_if;
    import replay_pkg::*;
    logic       en;
    logic       dllp_valid;
    logic       dllp_ready;
    logic       dllp_nak;
    seq_t       dllp_seq;
    logic       tlp_sent;
    logic       buf_wr;
    seq_t       buf_num_replay;
    logic [1:0] buf_rd;
    seq_t       buf_seq;
    logic       buf_tim_out;
    logic       buf_rep;
    seq_t       buf_replay_index;
    logic       replay_word_valid;
    logic       tx_hold;
    logic       link_retrain;
    logic       retrain_done;
    seq_t       next_seq;
    seq_t       ackd_seq;
    logic       dllp_err;
    modport master (
        input  en, dllp_valid, dllp_nak, dllp_seq, tlp_sent, buf_wr, buf_num_replay, retrain_done,
        output dllp_ready, buf_rd, buf_seq, buf_tim_out, buf_rep, buf_replay_index,
               replay_word_valid, tx_hold, link_retrain, next_seq, ackd_seq, dllp_err
    );
    modport slave (
        output en, dllp_valid, dllp_nak, dllp_seq, tlp_sent, buf_wr, buf_num_replay, retrain_done,
        input  dllp_ready, buf_rd, buf_seq, buf_tim_out, buf_rep, buf_replay_index,
               replay_word_valid, tx_hold, link_retrain, next_seq, ackd_seq, dllp_err
    );
endinterface

// File: rtl/replay_timer.sv
// replay_timer: saturating replay timer with clear, hold and expiry flag
module replay_timer #(
    parameter int LIMIT = 711
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] r_cnt;
    assign o_expired = r_cnt == W'(LIMIT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= i_clr ? '0 : (i_inc && !o_expired) ? r_cnt + W'(1) : r_cnt;
    end
endmodule

// File: rtl/replay_sched.sv
// replay_sched: DLL replay controller sequencing ACK/NAK purges, timeouts and buffer replays
module replay_sched
    import replay_pkg::*;
#(
    parameter int TIMER_LIMIT    = 711,
    parameter int REPLAY_NUM_MAX = 3
) (
    input logic      clk,
    input logic      rst,
    replay_if.master bus
);
    localparam int RN_W = $clog2(REPLAY_NUM_MAX + 1);
    state_t          r_state;
    seq_t            r_next_seq, r_ackd_seq, r_d, r_dllp_seq, r_len, r_idx, r_seq, r_index;
    logic [RN_W-1:0] r_rnum;
    logic [1:0]      r_rd;
    logic            r_nak, r_tim_out, r_rep, r_word_valid, r_retrain, r_err;
    seq_t            w_out, w_d;
    logic            w_accept, w_expired, w_clr, w_inc, w_skip;

    assign w_out    = seq_dist(r_next_seq - seq_t'(1), r_ackd_seq);
    assign w_d      = seq_dist(bus.dllp_seq, r_ackd_seq);
    assign w_accept = bus.dllp_valid && bus.dllp_ready;
    assign w_skip   = (bus.buf_num_replay == '1) || (w_out == '0);
    assign w_inc    = (r_state == IDLE) && (w_out != '0);
    assign w_clr    = (r_state == PURGE && !bus.buf_wr) || (r_state == LATCH && w_skip) ||
                      (r_state == REPLAY && r_idx == r_len);

    replay_timer #(.LIMIT(TIMER_LIMIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_en      (bus.en),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .o_expired (w_expired)
    );

    assign bus.dllp_ready        = bus.en && (r_state == IDLE);
    assign bus.tx_hold           = r_state != IDLE;
    assign bus.buf_rd            = r_rd;
    assign bus.buf_seq           = r_seq;
    assign bus.buf_tim_out       = r_tim_out;
    assign bus.buf_rep           = r_rep;
    assign bus.buf_replay_index  = r_index;
    assign bus.replay_word_valid = r_word_valid;
    assign bus.link_retrain      = r_retrain;
    assign bus.next_seq          = r_next_seq;
    assign bus.ackd_seq          = r_ackd_seq;
    assign bus.dllp_err          = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_next_seq   <= seq_t'(1);
            r_ackd_seq   <= '0;
            r_d          <= '0;
            r_dllp_seq   <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_rnum       <= '0;
            r_nak        <= 1'b0;
            r_rd         <= BUF_RD_NONE;
            r_seq        <= '0;
            r_tim_out    <= 1'b0;
            r_rep        <= 1'b0;
            r_index      <= '0;
            r_word_valid <= 1'b0;
            r_retrain    <= 1'b0;
            r_err        <= 1'b0;
        end else if (!bus.en) begin
            r_rd         <= BUF_RD_NONE;
            r_seq        <= '0;
            r_tim_out    <= 1'b0;
            r_rep        <= 1'b0;
            r_index      <= '0;
            r_word_valid <= 1'b0;
            r_retrain    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd         <= BUF_RD_NONE;
            r_seq        <= '0;
            r_tim_out    <= 1'b0;
            r_rep        <= 1'b0;
            r_index      <= '0;
            r_word_valid <= r_rep;
            r_retrain    <= 1'b0;
            r_err        <= 1'b0;
            if (bus.tlp_sent)
                r_next_seq <= r_next_seq + seq_t'(1);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_d > w_out)
                            r_err <= 1'b1;
                        else if (bus.dllp_nak || w_d != '0) begin
                            r_nak      <= bus.dllp_nak;
                            r_d        <= w_d;
                            r_dllp_seq <= bus.dllp_seq;
                            r_state    <= (w_d != '0) ? PURGE : REWIND;
                        end
                    end else if (w_expired) begin
                        r_nak   <= 1'b0;
                        r_state <= REWIND;
                    end
                end
                PURGE: begin
                    if (!bus.buf_wr) begin
                        r_rd       <= BUF_RD_PURGE;
                        r_seq      <= r_d;
                        r_ackd_seq <= r_dllp_seq;
                        r_rnum     <= '0;
                        r_state    <= r_nak ? REWIND : IDLE;
                    end
                end
                REWIND: begin
                    if (!bus.buf_wr) begin
                        if (r_rnum == RN_W'(REPLAY_NUM_MAX)) begin
                            r_retrain <= 1'b1;
                            r_rnum    <= '0;
                            r_state   <= RETRAIN;
                        end else begin
                            r_rd      <= r_nak ? BUF_RD_REWIND : BUF_RD_NONE;
                            r_tim_out <= !r_nak;
                            r_seq     <= r_ackd_seq + seq_t'(1);
                            r_rnum    <= r_rnum + RN_W'(1);
                            r_state   <= LATCH;
                        end
                    end
                end
                RETRAIN: begin
                    if (bus.retrain_done)
                        r_state <= REWIND;
                end
                LATCH: begin
                    r_len   <= bus.buf_num_replay;
                    r_idx   <= '0;
                    r_state <= w_skip ? IDLE : REPLAY;
                end
                REPLAY: begin
                    r_rep   <= 1'b1;
                    r_index <= r_idx;
                    r_idx   <= r_idx + seq_t'(1);
                    if (r_idx == r_len)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_replay_sched.sv
// tb_replay_sched: directed checks of purge, rewind, timeout, retrain, wrap and async reset
module tb_replay_sched;
    import replay_pkg::*;
    localparam int TIMER_LIMIT = 711;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    replay_if bus();
    replay_sched #(.TIMER_LIMIT(TIMER_LIMIT), .REPLAY_NUM_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.en             = 1'b1;
        bus.dllp_valid     = 1'b0;
        bus.dllp_nak       = 1'b0;
        bus.dllp_seq       = '0;
        bus.tlp_sent       = 1'b0;
        bus.buf_wr         = 1'b0;
        bus.buf_num_replay = '0;
        bus.retrain_done   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input int n);
        bus.tlp_sent = 1'b1;
        repeat (n) tick();
        bus.tlp_sent = 1'b0;
    endtask

    task automatic dllp(input logic nak, input int seq);
        bus.dllp_valid = 1'b1;
        bus.dllp_nak   = nak;
        bus.dllp_seq   = seq_t'(seq);
        tick();
        bus.dllp_valid = 1'b0;
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.buf_rd != 2'b00 || bus.buf_tim_out || bus.link_retrain || bus.dllp_err) && n <= max);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rem;
        int c;
        int sent;
        do_reset();
        check("rst_next_seq", bus.next_seq, 1);
        check("rst_ackd_seq", bus.ackd_seq, 0);
        check("rst_dllp_ready", bus.dllp_ready, 1);
        check("rst_tx_hold", bus.tx_hold, 0);
        check("rst_strobes", {bus.buf_rd, bus.buf_tim_out, bus.buf_rep, bus.link_retrain, bus.dllp_err}, 0);

        send(3);
        check("t1_next_seq", bus.next_seq, 4);
        bus.buf_wr = 1'b1;
        dllp(1'b0, 2);
        repeat (2) tick();
        check("t1_wait_rd", bus.buf_rd, 0);
        check("t1_wait_hold", bus.tx_hold, 1);
        check("t1_wait_ready", bus.dllp_ready, 0);
        bus.buf_wr = 1'b0;
        tick();
        check("t1_purge_rd", bus.buf_rd, 1);
        check("t1_purge_seq", bus.buf_seq, 2);
        check("t1_ackd_seq", bus.ackd_seq, 2);
        tick();
        check("t1_purge_once", bus.buf_rd, 0);
        check("t1_idle_hold", bus.tx_hold, 0);

        do_reset();
        send(3);
        bus.buf_num_replay = 12'd29;
        dllp(1'b1, 0);
        tick();
        check("t2_rewind_rd", bus.buf_rd, 2);
        check("t2_rewind_seq", bus.buf_seq, 1);
        check("t2_ackd_kept", bus.ackd_seq, 0);
        tick();
        check("t2_latch_rep", bus.buf_rep, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("t2_rep", bus.buf_rep, 1);
            check("t2_index", bus.buf_replay_index, i);
            check("t2_word_valid", bus.replay_word_valid, (i > 0) ? 1 : 0);
        end
        tick();
        check("t2_rep_end", bus.buf_rep, 0);
        check("t2_word_valid_tail", bus.replay_word_valid, 1);
        check("t2_idle_hold", bus.tx_hold, 0);
        tick();
        check("t2_word_valid_end", bus.replay_word_valid, 0);

        do_reset();
        send(3);
        bus.buf_num_replay = 12'd29;
        dllp(1'b1, 1);
        tick();
        check("t2b_purge_rd", bus.buf_rd, 1);
        check("t2b_purge_seq", bus.buf_seq, 1);
        tick();
        check("t2b_rewind_rd", bus.buf_rd, 2);
        check("t2b_rewind_seq", bus.buf_seq, 2);
        repeat (40) tick();
        check("t2b_idle", bus.tx_hold, 0);

        do_reset();
        bus.buf_num_replay = 12'd2;
        send(1);
        wait_strobe(800, n);
        check("t3_tim_out", bus.buf_tim_out, 1);
        check("t3_latency", (n >= TIMER_LIMIT + 1 && n <= TIMER_LIMIT + 3) ? 1 : 0, 1);
        check("t3_no_rd", bus.buf_rd, 0);
        check("t3_seq", bus.buf_seq, 1);
        for (int k = 2; k <= 3; k++) begin
            wait_strobe(800, n);
            check("t4_tim_out", bus.buf_tim_out, 1);
        end
        wait_strobe(800, n);
        check("t4_retrain", bus.link_retrain, 1);
        check("t4_retrain_no_tim", bus.buf_tim_out, 0);
        repeat (5) tick();
        check("t4_retrain_pulse", bus.link_retrain, 0);
        check("t4_stall_hold", bus.tx_hold, 1);
        check("t4_stall_tim", bus.buf_tim_out, 0);
        bus.retrain_done = 1'b1;
        tick();
        bus.retrain_done = 1'b0;
        wait_strobe(5, n);
        check("t4_after_retrain", bus.buf_tim_out, 1);
        check("t4_after_seq", bus.buf_seq, 1);
        wait_strobe(800, n);
        check("t4_count_restart", bus.buf_tim_out, 1);
        check("t4_count_no_retrain", bus.link_retrain, 0);

        do_reset();
        send(3);
        dllp(1'b0, 9);
        check("t5_err", bus.dllp_err, 1);
        check("t5_ackd", bus.ackd_seq, 0);
        check("t5_no_rd", bus.buf_rd, 0);
        tick();
        check("t5_err_pulse", bus.dllp_err, 0);
        check("t5_no_rd2", bus.buf_rd, 0);
        dllp(1'b0, 0);
        check("t5_dup_err", bus.dllp_err, 0);
        check("t5_dup_idle", bus.tx_hold, 0);
        tick();
        check("t5_dup_rd", bus.buf_rd, 0);
        bus.en       = 1'b0;
        bus.tlp_sent = 1'b1;
        tick();
        bus.tlp_sent = 1'b0;
        check("t5_en_hold", bus.next_seq, 4);
        check("t5_en_ready", bus.dllp_ready, 0);
        bus.en = 1'b1;

        do_reset();
        rem  = 4094;
        sent = 0;
        while (rem > 0) begin
            c = (rem > 600) ? 600 : rem;
            send(c);
            rem  -= c;
            sent += c;
            dllp(1'b0, sent);
            tick();
            check("t6_chunk_rd", bus.buf_rd, 1);
            check("t6_chunk_seq", bus.buf_seq, c);
        end
        check("t6_next_4095", bus.next_seq, 4095);
        check("t6_ackd_4094", bus.ackd_seq, 4094);
        send(2);
        check("t6_next_wrap", bus.next_seq, 1);
        dllp(1'b0, 0);
        tick();
        check("t6_wrap_rd", bus.buf_rd, 1);
        check("t6_wrap_seq", bus.buf_seq, 2);
        check("t6_wrap_ackd", bus.ackd_seq, 0);

        send(3);
        bus.buf_num_replay = 12'd29;
        dllp(1'b1, 0);
        tick();
        check("t6_rw_rd", bus.buf_rd, 2);
        repeat (3) tick();
        check("t6_mid_rep", bus.buf_rep, 1);
        check("t6_mid_index", bus.buf_replay_index, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_rep", bus.buf_rep, 0);
        check("t6_rst_index", bus.buf_replay_index, 0);
        check("t6_rst_wv", bus.replay_word_valid, 0);
        check("t6_rst_rd", bus.buf_rd, 0);
        check("t6_rst_hold", bus.tx_hold, 0);
        check("t6_rst_ready", bus.dllp_ready, 1);
        check("t6_rst_next", bus.next_seq, 1);
        check("t6_rst_ackd", bus.ackd_seq, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_rst_rep", bus.buf_rep, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
